// File: rtl/t_mem_rd_arbiter_if.sv
// Requester, ROM and read-return signals shared between t_mem_rd_arbiter and its neighbours.
// slave = arbiter side, master = requester/ROM side.
interface t_mem_rd_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] base0;
    logic [ADDR_WIDTH-1:0] base1;
    logic [ADDR_WIDTH-1:0] len0;
    logic [ADDR_WIDTH-1:0] len1;
    logic                  gnt0;
    logic                  gnt1;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_owner;
    logic                  rd_last;
    logic                  busy;

    modport slave (
        input  req0, req1, base0, base1, len0, len1, mem_q,
        output gnt0, gnt1, mem_addr, rd_data, rd_valid, rd_owner, rd_last, busy
    );

    modport master (
        output req0, req1, base0, base1, len0, len1, mem_q,
        input  gnt0, gnt1, mem_addr, rd_data, rd_valid, rd_owner, rd_last, busy
    );
endinterface

// File: rtl/t_mem_rd_arbiter.sv
// Burst read arbiter for the single-port t-value ROM; tags returning words with owner/last.
// T_MEM_ARB_FIXED_PRIO_EN: req0 always wins ties (default: round robin).
module t_mem_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    t_mem_rd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic valid;
        logic owner;
        logic last;
    } pipe_entry_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_next;
    logic                  owner_q, owner_next;
    logic                  gnt0_q, gnt0_next;
    logic                  gnt1_q, gnt1_next;
    logic                  busy_q;
    pipe_entry_t           pipe_q [READ_LATENCY];
    pipe_entry_t           pipe_in;
    logic                  pipe_pending;
    logic                  grant_c;
    logic                  winner;

    assign grant_c = (state == IDLE) && (bus.req0 || bus.req1);

`ifdef T_MEM_ARB_FIXED_PRIO_EN
    assign winner = !bus.req0;
`else
    logic last_winner_q;

    // Ties go to whoever did not win last; a lone request always wins.
    assign winner = (bus.req0 && bus.req1) ? !last_winner_q : bus.req1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        last_winner_q <= 1'b1;
        else if (grant_c) last_winner_q <= winner;
    end
`endif

    // Entries that would still be valid after this cycle's shift keep DRAIN alive.
    always_comb begin
        pipe_pending = 1'b0;
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++)
            pipe_pending = pipe_pending | pipe_q[i].valid;
    end

    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        cnt_next   = cnt_q;
        owner_next = owner_q;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        pipe_in    = '0;
        unique case (state)
            IDLE: begin
                if (grant_c) begin
                    state_next = ISSUE;
                    gnt0_next  = !winner;
                    gnt1_next  = winner;
                    addr_next  = winner ? bus.base1 : bus.base0;
                    cnt_next   = winner ? bus.len1  : bus.len0;
                    owner_next = winner;
                end
            end
            ISSUE: begin
                pipe_in.valid = 1'b1;
                pipe_in.owner = owner_q;
                pipe_in.last  = (cnt_q == '0);
                if (cnt_q == '0) begin
                    state_next = DRAIN;
                end else begin
                    addr_next = addr_q + ADDR_WIDTH'(1);
                    cnt_next  = cnt_q - ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (!pipe_pending) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            addr_q  <= addr_next;
            cnt_q   <= cnt_next;
            owner_q <= owner_next;
            gnt0_q  <= gnt0_next;
            gnt1_q  <= gnt1_next;
            busy_q  <= (state_next != IDLE);
        end
    end

    // Tag pipe tracks the ROM read latency so tags line up with mem_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.mem_addr = addr_q;
    assign bus.busy     = busy_q;
    assign bus.rd_data  = bus.mem_q;
    assign bus.rd_valid = pipe_q[READ_LATENCY-1].valid;
    assign bus.rd_owner = pipe_q[READ_LATENCY-1].owner;
    assign bus.rd_last  = pipe_q[READ_LATENCY-1].last;
endmodule

// File: tb/tb_t_mem_rd_arbiter.sv
// Directed bench for t_mem_rd_arbiter with a 2-cycle ROM model; follows each burst cycle by cycle.
module tb_t_mem_rd_arbiter;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int          RL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [DW-1:0] rom_q1;

    t_mem_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    t_mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {8'hC3, 1'b0, a, ~{1'b0, a}, 8'h5A};
    endfunction

    // ROM: registered address, registered output
    always @(posedge clock) begin
        rom_q1    <= rom_word(bus.mem_addr);
        bus.mem_q <= rom_q1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_gnt(input logic who, input int exp_cycles);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clock);
            n++;
            seen = bus.gnt0 || bus.gnt1;
        end
        check("gnt_latency", 32'(n), 32'(exp_cycles));
        if (seen) check("gnt_who", 32'(bus.gnt1), 32'(who));
        if (who) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
    endtask

    // Called at the negedge of the grant cycle; returns at the rd_last cycle.
    task automatic follow_burst(input logic who, input logic [AW-1:0] base, input logic [AW-1:0] len);
        logic [AW-1:0] a;
        int n = int'(len) + RL;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clock);
            if (k <= int'(len)) begin
                a = base + AW'(k);
                check("mem_addr", 32'(bus.mem_addr), 32'(a));
            end
            check("gnt_own", 32'(who ? bus.gnt1 : bus.gnt0), 32'(k == 0));
            check("gnt_other", 32'(who ? bus.gnt0 : bus.gnt1), 32'd0);
            check("busy", 32'(bus.busy), 32'd1);
            if (k >= RL) begin
                a = base + AW'(k - RL);
                check("rd_valid", 32'(bus.rd_valid), 32'd1);
                check("rd_owner", 32'(bus.rd_owner), 32'(who));
                check("rd_data", bus.rd_data, rom_word(a));
                check("rd_last", 32'(bus.rd_last), 32'(k == n));
            end else begin
                check("rd_valid_early", 32'(bus.rd_valid), 32'd0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        check({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, "_rd_owner"}, 32'(bus.rd_owner), 32'd0);
        check({tag, "_rd_last"}, 32'(bus.rd_last), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, nv;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.base0 = '0; bus.base1 = '0; bus.len0 = '0; bus.len1 = '0;

        // Reset state
        @(negedge clock);
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Simultaneous requests after reset: req0 first, then alternation
        @(negedge clock);
        bus.req0 = 1'b1; bus.base0 = 7'h20; bus.len0 = 7'd0;
        bus.req1 = 1'b1; bus.base1 = 7'h30; bus.len1 = 7'd0;
        wait_gnt(1'b0, 1);
        follow_burst(1'b0, 7'h20, 7'd0);
        wait_gnt(1'b1, 2);
        follow_burst(1'b1, 7'h30, 7'd0);
        bus.req0 = 1'b1; bus.base0 = 7'h21;
        bus.req1 = 1'b1; bus.base1 = 7'h31;
        wait_gnt(1'b0, 2);
        follow_burst(1'b0, 7'h21, 7'd0);
        wait_gnt(1'b1, 2);
        follow_burst(1'b1, 7'h31, 7'd0);

        // req0 arrives while req1 burst is running
        bus.req1 = 1'b1; bus.base1 = 7'h40; bus.len1 = 7'd2;
        wait_gnt(1'b1, 2);
        bus.req0 = 1'b1; bus.base0 = 7'h50; bus.len0 = 7'd1;
        follow_burst(1'b1, 7'h40, 7'd2);
        wait_gnt(1'b0, 2);
        follow_burst(1'b0, 7'h50, 7'd1);

        // Four-word burst from req0
        bus.req0 = 1'b1; bus.base0 = 7'h10; bus.len0 = 7'd3;
        wait_gnt(1'b0, 2);
        follow_burst(1'b0, 7'h10, 7'd3);

        // Address wrap from req1
        bus.req1 = 1'b1; bus.base1 = 7'h7E; bus.len1 = 7'd3;
        wait_gnt(1'b1, 2);
        follow_burst(1'b1, 7'h7E, 7'd3);

        // Reset on the second returned word of an 8-word burst
        bus.req0 = 1'b1; bus.base0 = 7'h60; bus.len0 = 7'd7;
        wait_gnt(1'b0, 2);
        for (int k = 1; k <= 3; k++) @(negedge clock);
        check("mid_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("mid_rd_data", bus.rd_data, rom_word(7'h61));
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.rd_valid || bus.busy) nv++;
        end
        check("post_reset_quiet", 32'(nv), 32'd0);
        bus.req0 = 1'b1; bus.base0 = 7'h05; bus.len0 = 7'd1;
        wait_gnt(1'b0, 1);
        follow_burst(1'b0, 7'h05, 7'd1);

        // Both requests held continuously
        bus.req0 = 1'b1; bus.base0 = 7'h00; bus.len0 = 7'd0;
        bus.req1 = 1'b1; bus.base1 = 7'h01; bus.len1 = 7'd0;
        g0 = 0; g1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (bus.gnt0) g0++;
            if (bus.gnt1) g1++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("held_total_gnts", 32'(g0 + g1), 32'd10);
`ifdef T_MEM_ARB_FIXED_PRIO_EN
        check("held_gnt1", 32'(g1), 32'd0);
`else
        check("held_gnt1", 32'(g1), 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
